// File: rtl/hazard_unit_pkg.sv
// ----------------------------------------------------------------------------
// hazard_unit_pkg
//   Shared encodings for the hazard/forwarding controller and the ID-stage
//   decoder (ctrl).
//   - inst_type_e : instruction class reported by ctrl for the ID instruction
//   - fwd_sel_e   : operand source select driven to the ID comparator/JR
//                   operand muxes and to the EX ALU operand muxes
//   - small helpers classifying instruction classes
// ----------------------------------------------------------------------------
package hazard_unit_pkg;

   typedef enum logic [2:0] {
      INST_NORMAL = 3'd0,
      INST_LW     = 3'd1,
      INST_JR     = 3'd2,
      INST_BEQ    = 3'd3,
      INST_J_TYPE = 3'd4
   } inst_type_e;

   typedef enum logic [1:0] {
      FWD_REG   = 2'b00,   // register file read data
      FWD_EXMEM = 2'b01,   // EX/MEM ALU result
      FWD_MEMWB = 2'b10    // MEM/WB write-back data
   } fwd_sel_e;

   // Instructions that consume their operands already in ID (comparator, JR
   // target) and therefore cannot take an EX-stage result.
   function automatic logic is_id_consumer(input inst_type_e t);
      return (t == INST_BEQ) || (t == INST_JR);
   endfunction

   // Instruction redirects the fetch stream when it leaves ID.
   function automatic logic is_redirect(input inst_type_e t, input logic beq_taken);
      return (t == INST_J_TYPE) || (t == INST_JR) || ((t == INST_BEQ) && beq_taken);
   endfunction

endpackage

// File: rtl/hazard_unit_fwd_sel.sv
// ----------------------------------------------------------------------------
// fwd_sel
//   Forward-source selector for one source operand.
//   Ports:
//     mem_valid/mem_reg_write/mem_dst/mem_is_lw : MEM-stage shadow entry
//     wb_valid/wb_reg_write/wb_dst              : WB-stage shadow entry
//     src      : source register number
//     use_src  : operand is actually read
//     sel      : FWD_REG / FWD_EXMEM / FWD_MEMWB
//   SKIP_MEM_LW=1 is used for ID-stage operands: a load in MEM has no data
//   on the EX/MEM ALU path yet, so it must not be selected from there.
//   MEM has priority over WB (youngest producer wins). Register 0 never
//   forwards.
// ----------------------------------------------------------------------------
module fwd_sel
   import hazard_unit_pkg::*;
#(
   parameter int unsigned REG_AW      = 5,
   parameter bit          SKIP_MEM_LW = 1'b0
) (
   input  logic              mem_valid,
   input  logic              mem_reg_write,
   input  logic [REG_AW-1:0] mem_dst,
   input  logic              mem_is_lw,
   input  logic              wb_valid,
   input  logic              wb_reg_write,
   input  logic [REG_AW-1:0] wb_dst,
   input  logic [REG_AW-1:0] src,
   input  logic              use_src,
   output logic [1:0]        sel
);

   logic src_nonzero;
   logic hit_mem;
   logic hit_wb;

   always_comb begin
      src_nonzero = (src != '0);
      hit_mem     = use_src && src_nonzero && mem_valid && mem_reg_write
                    && (mem_dst == src) && !(SKIP_MEM_LW && mem_is_lw);
      hit_wb      = use_src && src_nonzero && wb_valid && wb_reg_write
                    && (wb_dst == src);
   end

   always_comb begin
      sel = FWD_REG;
      if (hit_mem) begin
         sel = FWD_EXMEM;
      end else if (hit_wb) begin
         sel = FWD_MEMWB;
      end
   end

endmodule

// File: rtl/hazard_unit.sv
// ----------------------------------------------------------------------------
// hazard_unit
//   Pipeline hazard / forwarding controller placed after the ID decoder.
//   Keeps a shadow of the EX, MEM and WB occupants and produces stall,
//   bubble, flush and forward selects with zero latency from the shadows and
//   the ID-stage inputs.
//   Ports:
//     clk, rst_n          : clock (rising edge), async active-low reset
//     id_inst_type        : instruction class of the ID instruction
//     id_reg_write        : ID instruction writes a register
//     id_wr_num           : resolved destination of the ID instruction
//     id_rs, id_rt        : ID source registers
//     id_use_rs/rt        : ID instruction reads rs / rt
//     id_beq_taken        : ID comparator result
//     pc_en, if_id_en     : front-end enables (low while stalling)
//     if_id_flush         : IF/ID loads a NOP (redirect)
//     id_ex_bubble        : ID/EX loads a NOP (stall)
//     id_fwd_a/b          : ID comparator / JR operand source select
//     ex_fwd_a/b          : EX ALU operand source select
//     stall_cnt/flush_cnt : wrapping event counters
// ----------------------------------------------------------------------------
module hazard_unit
   import hazard_unit_pkg::*;
#(
   parameter int unsigned CNT_W  = 32,
   parameter int unsigned REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [2:0]        id_inst_type,
   input  logic              id_reg_write,
   input  logic [REG_AW-1:0] id_wr_num,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_use_rs,
   input  logic              id_use_rt,
   input  logic              id_beq_taken,
   output logic              pc_en,
   output logic              if_id_en,
   output logic              if_id_flush,
   output logic              id_ex_bubble,
   output logic [1:0]        id_fwd_a,
   output logic [1:0]        id_fwd_b,
   output logic [1:0]        ex_fwd_a,
   output logic [1:0]        ex_fwd_b,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   typedef struct packed {
      logic              valid;
      logic              reg_write;
      logic [REG_AW-1:0] dst;
      logic              is_lw;
      logic [REG_AW-1:0] rs;
      logic [REG_AW-1:0] rt;
      logic              use_rs;
      logic              use_rt;
   } entry_t;

   entry_t     ex_q, mem_q, wb_q;
   entry_t     id_entry;
   inst_type_e id_type;

   logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
   logic ex_hit, mem_hit;
   logic stall;
   logic redirect;

   // Producer entry e writes register r that the consumer actually reads.
   function automatic logic match(input entry_t e, input logic [REG_AW-1:0] r,
                                  input logic use_r);
      return use_r && e.valid && e.reg_write && (e.dst == r) && (r != '0);
   endfunction

   assign id_type = inst_type_e'(id_inst_type);

   always_comb begin
      id_entry           = '0;
      id_entry.valid     = 1'b1;
      id_entry.reg_write = id_reg_write;
      id_entry.dst       = id_wr_num;
      id_entry.is_lw     = (id_type == INST_LW);
      id_entry.rs        = id_rs;
      id_entry.rt        = id_rt;
      id_entry.use_rs    = id_use_rs;
      id_entry.use_rt    = id_use_rt;
   end

   // ------------------------------------------------------------------------
   // Hazard detection
   // ------------------------------------------------------------------------
   always_comb begin
      ex_hit_rs  = match(ex_q,  id_rs, id_use_rs);
      ex_hit_rt  = match(ex_q,  id_rt, id_use_rt);
      mem_hit_rs = match(mem_q, id_rs, id_use_rs);
      mem_hit_rt = match(mem_q, id_rt, id_use_rt);
      ex_hit     = ex_hit_rs || ex_hit_rt;
      mem_hit    = mem_hit_rs || mem_hit_rt;
   end

   // ID consumers need the value at the start of EX's successor: any EX
   // producer is too late, and a load in MEM has not produced data yet.
   // Everyone else only waits on a load sitting directly in EX.
   always_comb begin
      if (is_id_consumer(id_type)) begin
         stall = ex_hit || (mem_hit && mem_q.is_lw);
      end else begin
         stall = ex_hit && ex_q.is_lw;
      end
   end

   // Redirect is gated by rst_n so if_id_flush holds its reset value while
   // reset is asserted, independent of what ctrl presents.
   assign redirect = rst_n && !stall && is_redirect(id_type, id_beq_taken);

   always_comb begin
      pc_en        = !stall;
      if_id_en     = !stall;
      id_ex_bubble = stall;
      if_id_flush  = redirect;
   end

   // ------------------------------------------------------------------------
   // Shadow pipeline and counters
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q      <= '0;
         mem_q     <= '0;
         wb_q      <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         wb_q  <= mem_q;
         mem_q <= ex_q;
         ex_q  <= stall ? entry_t'('0) : id_entry;
         if (stall) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
         if (redirect) begin
            flush_cnt <= flush_cnt + CNT_W'(1);
         end
      end
   end

   // ------------------------------------------------------------------------
   // Forward selects
   // ------------------------------------------------------------------------
   fwd_sel #(.REG_AW(REG_AW), .SKIP_MEM_LW(1'b1)) u_id_fwd_a (
      .mem_valid     (mem_q.valid),
      .mem_reg_write (mem_q.reg_write),
      .mem_dst       (mem_q.dst),
      .mem_is_lw     (mem_q.is_lw),
      .wb_valid      (wb_q.valid),
      .wb_reg_write  (wb_q.reg_write),
      .wb_dst        (wb_q.dst),
      .src           (id_rs),
      .use_src       (id_use_rs),
      .sel           (id_fwd_a)
   );

   fwd_sel #(.REG_AW(REG_AW), .SKIP_MEM_LW(1'b1)) u_id_fwd_b (
      .mem_valid     (mem_q.valid),
      .mem_reg_write (mem_q.reg_write),
      .mem_dst       (mem_q.dst),
      .mem_is_lw     (mem_q.is_lw),
      .wb_valid      (wb_q.valid),
      .wb_reg_write  (wb_q.reg_write),
      .wb_dst        (wb_q.dst),
      .src           (id_rt),
      .use_src       (id_use_rt),
      .sel           (id_fwd_b)
   );

   fwd_sel #(.REG_AW(REG_AW), .SKIP_MEM_LW(1'b0)) u_ex_fwd_a (
      .mem_valid     (mem_q.valid),
      .mem_reg_write (mem_q.reg_write),
      .mem_dst       (mem_q.dst),
      .mem_is_lw     (mem_q.is_lw),
      .wb_valid      (wb_q.valid),
      .wb_reg_write  (wb_q.reg_write),
      .wb_dst        (wb_q.dst),
      .src           (ex_q.rs),
      .use_src       (ex_q.valid && ex_q.use_rs),
      .sel           (ex_fwd_a)
   );

   fwd_sel #(.REG_AW(REG_AW), .SKIP_MEM_LW(1'b0)) u_ex_fwd_b (
      .mem_valid     (mem_q.valid),
      .mem_reg_write (mem_q.reg_write),
      .mem_dst       (mem_q.dst),
      .mem_is_lw     (mem_q.is_lw),
      .wb_valid      (wb_q.valid),
      .wb_reg_write  (wb_q.reg_write),
      .wb_dst        (wb_q.dst),
      .src           (ex_q.rt),
      .use_src       (ex_q.valid && ex_q.use_rt),
      .sel           (ex_fwd_b)
   );

   // Shadow fields kept for completeness of the occupant record but not
   // consumed downstream of MEM.
   logic unused_shadow;
   assign unused_shadow = ^{mem_q.rs, mem_q.rt, mem_q.use_rs, mem_q.use_rt,
                            wb_q.is_lw, wb_q.rs, wb_q.rt, wb_q.use_rs, wb_q.use_rt};

endmodule
